// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_pkg                                                                    |
// | Shared types and constants for the AES byte-permutation sequencer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [7:0] byte_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_FEED  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/aes_bpu_valid_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_bpu_valid_pipe                                                         |
// | Valid-bit shadow of the permutation unit; advances with the unit.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_bpu_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic din_i,
  output logic tail_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] w_shifted;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_shifted = din_i;
    end else begin : g_multi
      assign w_shifted = {vld_q[DEPTH-2:0], din_i};
    end
  endgenerate

  always_comb begin
    vld_d = vld_q;
    if (clr_i) begin
      vld_d = '0;
    end else if (en_i) begin
      vld_d = w_shifted;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign tail_o = vld_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/aes_bpu_round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_bpu_round_sequencer                                                    |
// | Streams AES state bytes through the byte-serial ShiftRows unit per round.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_bpu_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int PERM_LAT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] round_idx,
  input  logic [7:0] s_byte,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_byte,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       bpu_rst_synch,
  output logic       bpu_shift_left,
  output logic [7:0] bpu_in_byte,
  input  logic [7:0] bpu_out_byte
);

  localparam logic [4:0] c_LAST_BYTE  = 5'(AES_STATE_BYTES - 1);
  localparam logic [4:0] c_FULL       = 5'(AES_STATE_BYTES);
  localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t     state_q,   state_d;
  logic [4:0] in_cnt_q,  in_cnt_d;
  logic [4:0] out_cnt_q, out_cnt_d;
  logic [3:0] round_q,   round_d;
  byte_t      out_q,     out_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q,  m_last_d;
  logic       done_q,    done_d;

  logic w_tail;
  logic w_slot_free;
  logic w_adv;
  logic w_capture;
  logic w_frame_end;

  aes_bpu_valid_pipe #(
    .DEPTH (PERM_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ST_START),
    .en_i   (w_adv),
    .din_i  (state_q == ST_FEED),
    .tail_o (w_tail)
  );

  // A bubble at the tail, an empty output slot or a taking sink all let the unit advance.
  assign w_slot_free = !w_tail || !m_valid_q || m_ready;

  always_comb begin
    w_adv       = 1'b0;
    s_ready     = 1'b0;
    bpu_in_byte = 8'h00;
    case (state_q)
      ST_FEED: begin
        s_ready     = w_slot_free;
        w_adv       = s_valid && w_slot_free;
        bpu_in_byte = s_byte;
      end
      ST_DRAIN: begin
        w_adv = w_slot_free;
      end
      default: begin
        w_adv = 1'b0;
      end
    endcase
  end

  assign w_capture   = w_adv && w_tail;
  assign w_frame_end = w_capture && (out_cnt_q == c_LAST_BYTE);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    round_d   = round_q;
    out_d     = out_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;

    if (w_capture) begin
      out_d     = bpu_out_byte;
      m_valid_d = 1'b1;
      m_last_d  = (out_cnt_q == c_LAST_BYTE);
      out_cnt_d = out_cnt_q + 5'd1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START;
          round_d   = 4'd0;
          in_cnt_d  = 5'd0;
          out_cnt_d = 5'd0;
        end
      end
      ST_START: begin
        in_cnt_d  = 5'd0;
        out_cnt_d = 5'd0;
        state_d   = ST_FEED;
      end
      ST_FEED: begin
        if (w_adv) begin
          in_cnt_d = in_cnt_q + 5'd1;
          if (in_cnt_d == c_FULL) begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // The frame ends on the sixteenth capture; the final byte may still be waiting on the sink.
    if (w_frame_end) begin
      in_cnt_d  = 5'd0;
      out_cnt_d = 5'd0;
      if (round_q < c_LAST_ROUND) begin
        round_d = round_q + 4'd1;
        state_d = ST_START;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= 5'd0;
      out_cnt_q <= 5'd0;
      round_q   <= 4'd0;
      out_q     <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      round_q   <= round_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign round_idx      = round_q;
  assign m_byte         = out_q;
  assign m_valid        = m_valid_q;
  assign m_last         = m_last_q;
  assign bpu_rst_synch  = (state_q == ST_START);
  assign bpu_shift_left = w_adv;

endmodule
`default_nettype wire

// File: tb/tb_aes_bpu_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_bpu_round_sequencer                                                 |
// | Scoreboard bench: directed AES blocks through a delay-line unit model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_bpu_round_sequencer;

  localparam int NR = 2;
  localparam int PL = 4;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] s_byte  = 8'h00;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic       busy, done, s_ready, m_valid, m_last;
  logic       bpu_rst_synch, bpu_shift_left;
  logic [3:0] round_idx;
  logic [7:0] m_byte, bpu_in_byte, bpu_out_byte;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_hs = 0;
  int s_since = 0;
  int pulses = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  bit chk_timing = 1'b0;
  bit prev_rs = 1'b0;
  bit prev_done = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [7:0] pipe [PL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_bpu_round_sequencer #(
    .NUM_ROUNDS (NR),
    .PERM_LAT   (PL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .round_idx      (round_idx),
    .s_byte         (s_byte),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_byte         (m_byte),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .bpu_rst_synch  (bpu_rst_synch),
    .bpu_shift_left (bpu_shift_left),
    .bpu_in_byte    (bpu_in_byte),
    .bpu_out_byte   (bpu_out_byte)
  );

  // Unit model: PL-stage delay line that also scrambles each byte with 0x5A.
  always @(posedge clk or negedge rst) begin
    if (!rst || bpu_rst_synch) begin
      for (int i = 0; i < PL; i++) pipe[i] <= 8'h00;
    end else if (bpu_shift_left) begin
      pipe[0] <= bpu_in_byte ^ 8'h5A;
      for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bpu_out_byte = pipe[PL-1];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (s_valid && s_ready) s_since++;
      if (bpu_rst_synch) begin
        chk("rst_synch_width", {31'd0, prev_rs}, 0);
        chk("shift_in_start", {31'd0, bpu_shift_left}, 0);
        chk("round_at_start", {28'd0, round_idx}, pulses);
        if (pulses > 0) chk("s_hs_per_round", s_since, 16);
        s_since   = 0;
        pulses++;
        start_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        m_hs++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m_unexpected: got byte %0h with empty scoreboard", m_byte);
        end else begin
          e = exp_q.pop_front();
          chk("m_byte", {24'd0, m_byte}, {24'd0, e[7:0]});
          chk("m_last", {31'd0, m_last}, {31'd0, e[8]});
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_width", {31'd0, prev_done}, 0);
        chk("done_m_last", {30'd0, m_valid, m_last}, 32'd3);
        chk("done_round", {28'd0, round_idx}, NR - 1);
        chk("done_s_hs", s_since, 16);
        chk("done_pulses", pulses, NR);
        if (chk_timing) chk("done_latency", cyc - start_cyc, 1 + 16 + PL);
      end
      prev_rs   = bpu_rst_synch;
      prev_done = done;
    end else begin
      prev_rs   = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last, input bit gap);
    bit ok;
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
      chk("gap_no_shift", {31'd0, bpu_shift_left}, 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_byte  = b;
    ok      = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        exp_q.push_back({last, b ^ 8'h5A});
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL s_accept_timeout: byte %0h not accepted, required accept within 300 cycles", b);
    end
  endtask

  task automatic do_stall();
    logic [7:0] sb;
    for (int t = 0; t < 400 && m_hs < 5; t++) @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    sb = m_byte;
    chk("stall_valid_first", {31'd0, m_valid}, 1);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk("stall_byte", {24'd0, m_byte}, {24'd0, sb});
      chk("stall_valid", {31'd0, m_valid}, 1);
      if (k == 9) begin
        chk("stall_s_ready", {31'd0, s_ready}, 0);
        chk("stall_shift", {31'd0, bpu_shift_left}, 0);
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
  endtask

  task automatic do_poke();
    for (int t = 0; t < 600 && m_hs < 20; t++) @(posedge clk);
    #1;
    chk("poke_round_before", {28'd0, round_idx}, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("poke_round_after", {28'd0, round_idx}, 1);
    chk("poke_busy", {31'd0, busy}, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_block(input bit gaps, input bit stall, input bit timing,
                           input bit poke, input logic [7:0] base);
    m_hs = 0; done_cnt = 0; pulses = 0; s_since = 0; chk_timing = timing;
    pulse_start();
    fork
      begin
        for (int r = 0; r < NR; r++)
          for (int i = 0; i < 16; i++)
            send_byte(base + 8'(r * 16 + i), (i == 15), gaps && i[0]);
        s_valid = 1'b0;
      end
      begin
        if (stall) do_stall();
      end
      begin
        if (poke) do_poke();
      end
    join
    for (int t = 0; t < 500 && done_cnt == 0; t++) @(negedge clk);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("m_hs_total", m_hs, 16 * NR);
    chk("busy_after", {31'd0, busy}, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_round"}, {28'd0, round_idx}, 0);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 0);
    chk({tag, "_m_last"}, {31'd0, m_last}, 0);
    chk({tag, "_m_byte"}, {24'd0, m_byte}, 0);
    chk({tag, "_rst_synch"}, {31'd0, bpu_rst_synch}, 0);
    chk({tag, "_shift"}, {31'd0, bpu_shift_left}, 0);
    chk({tag, "_in_byte"}, {24'd0, bpu_in_byte}, 0);
  endtask

  task automatic reset_mid();
    m_hs = 0; done_cnt = 0; pulses = 0; s_since = 0; chk_timing = 1'b0;
    pulse_start();
    for (int i = 0; i < 22; i++) send_byte(8'h80 + 8'(i), (i == 15), 1'b0);
    chk("pre_reset_round", {28'd0, round_idx}, 1);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    repeat (3) @(posedge clk);
    chk("reset_no_done", done_cnt, 0);
    s_valid = 1'b0;
    exp_q.delete();
    #1 rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_block(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    run_block(1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
    run_block(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0);
    run_block(1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
    reset_mid();
    run_block(1'b0, 1'b0, 1'b1, 1'b0, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aes_bpu_round_sequencer.md
Name: aes_bpu_round_sequencer

Overview:
- Sequences the byte-serial ShiftRows permutation unit for AES rounds.
- Accepts an AES state as a 16-byte valid/ready stream and emits the permuted bytes on a valid/ready stream.
- Drives the unit's rst_synch/shift_left controls and holds the unit during back-pressure.
- Counts bytes and rounds, and flags the last byte of each round and the end of each block.

Parameters:
- NUM_ROUNDS, 10, frames (rounds) per block; legal range 1..15.
- PERM_LAT, 4, permutation-unit latency in advances: a byte fed on advance n appears on bpu_out_byte during advance n+PERM_LAT; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  begin a block; sampled only in IDLE.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the final byte of round NUM_ROUNDS-1 is captured.
- round_idx  out  4  current round, 0..NUM_ROUNDS-1.
- s_byte  in  8  input state byte.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid&&s_ready.
- m_byte  out  8  output byte, registered.
- m_valid  out  1  output valid, registered.
- m_last  out  1  marks byte 15 of a round.
- m_ready  in  1  downstream accept.
- bpu_rst_synch  out  1  synchronous clear of the unit's internal controller.
- bpu_shift_left  out  1  advance enable for the unit; when low the unit holds.
- bpu_in_byte  out  8  byte fed to the unit.
- bpu_out_byte  in  8  unit output.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs, in_cnt, out_cnt, round_idx, vld_sr and out_q are 0.
- States: IDLE, START, FEED, DRAIN.
- IDLE: on start=1 go to START with round_idx=0. start outside IDLE is ignored.
- START: for one cycle, bpu_rst_synch=1, bpu_shift_left=0, in_cnt=0, out_cnt=0, vld_sr=0. Next state is FEED.
- slot_free = !vld_sr[PERM_LAT-1] || !m_valid || m_ready.
- FEED: s_ready = slot_free; adv = s_valid && slot_free; bpu_in_byte = s_byte. When in_cnt reaches 16, go to DRAIN.
- DRAIN: s_ready=0; adv = slot_free; bpu_in_byte = 0 (bubble).
- Every state: bpu_shift_left = adv.
- On adv:
  - vld_sr shifts left, inserting (state==FEED).
  - In FEED, in_cnt increments.
  - If vld_sr[PERM_LAT-1]=1: out_q takes bpu_out_byte, m_valid becomes 1, m_last = (out_cnt==15), and out_cnt increments.
- m_valid && m_ready with no capture in the same cycle clears m_valid and m_last.
- Back-pressure:
  - With m_valid=1, m_ready=0 and a valid byte at the pipe tail, there is no adv. The unit and counters hold, and s_ready=0.
  - A bubble at the tail never blocks adv.
- Frame end (out_cnt becomes 16):
  - If round_idx < NUM_ROUNDS-1: increment round_idx and go to START.
  - Otherwise: pulse done and go to IDLE. m_valid/m_last of the final byte remain until accepted.
- A pending m_valid from the previous round may drain during START/FEED of the next round. In START no adv occurs, and the accept clears m_valid normally.
- Per round: exactly 16 s handshakes and 16 m handshakes; output byte order is as produced by the unit.
- Minimum round time with no stalls: 1 (START) + 16 + PERM_LAT cycles.
- A reset mid-block aborts immediately; no done pulse is issued.

Decomposition:
- Shared package aes_pkg:
  - state enum (IDLE, START, FEED, DRAIN);
  - AES_STATE_BYTES=16;
  - byte_t (logic [7:0]).
- One sub-module: aes_bpu_valid_pipe, the PERM_LAT-deep valid shift register with enable. The FSM and counters stay in the top module.
- At integration, the top instantiates beside Byte_Permutation_Unit, driving its rst_synch, shift_left and in_byte.

Test Plan:
- Reset/idle (PERM_LAT=4, NUM_ROUNDS=2): rst low mid-FEED -> all outputs 0 and state IDLE asynchronously; no done.
- Single block, no stalls (NUM_ROUNDS=1): start, then bytes 0x00..0x0F streamed with m_ready=1 -> bpu_rst_synch high for exactly 1 cycle, 16 m handshakes, m_last on the 16th, done 21 cycles after START entry.
- Source gaps: s_valid toggled 1/0 -> bpu_shift_left low on every gap, output bytes unchanged versus the reference model, in_cnt never exceeds 16.
- Sink back-pressure: m_ready=0 for 10 cycles mid-frame -> m_byte/m_valid stable, s_ready=0 once the tail is valid, no byte lost or duplicated.
- Multi-round (NUM_ROUNDS=2): round_idx goes 0->1, START re-entered with rst_synch pulse, 32 m handshakes total, done only after the second m_last.
- start asserted while busy -> ignored; round_idx and counters unaffected.
